vga_mode_sched: RTL and testbench



---
 rtl/vga_mode_sched.sv | 145 ++++++++++++++
 tb/tb_vga_mode_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sched.sv
// Frame-aligned RGB/YPbPr select sequencer: blanks the picture around each
// mode switch, learns vsync polarity and falls back to a timeout without vsync.
module vga_mode_sched #(
    parameter int BLANK_FRAMES = 2,
    parameter int TO_W         = 22,
    parameter int CNT_W        = 22
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync,
    input  logic ypbpr_req,
    output logic ypbpr_en,
    output logic blank,
    output logic busy,
    output logic vs_pol,
    output logic forced
);
    typedef enum logic [1:0] {IDLE, WAIT, PRE, POST} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]  TMR_MAX   = '1;
    localparam logic [TO_W-1:0]  TMR_ONE   = TO_W'(1);
    localparam logic [3:0]       FCNT_LAST = 4'(BLANK_FRAMES - 1);

    state_t           state, state_nxt;
    logic             vs_r, vs_d;
    logic             rise, fall, fs, fx, ev;
    logic [CNT_W-1:0] hi_cnt, lo_cnt, hi_len, lo_len;
    logic             hi_v, lo_v;
    logic [TO_W-1:0]  timer, timer_nxt;
    logic             target, target_nxt;
    logic             en_nxt, blank_nxt;
    logic [3:0]       fcnt, fcnt_nxt;

    assign rise = vs_r & ~vs_d;
    assign fall = ~vs_r & vs_d;
    // Frame start is the leading edge of the active vsync pulse.
    assign fs   = vs_pol ? rise : fall;
    assign fx   = (timer == TMR_MAX);
    assign ev   = fs | fx;

    // The shorter vsync phase is the active one; ties resolve to active-low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
            hi_len <= '0;
            lo_len <= '0;
            hi_v   <= 1'b0;
            lo_v   <= 1'b0;
            vs_pol <= 1'b0;
        end else begin
            vs_r <= vsync;
            vs_d <= vs_r;
            if (rise)
                hi_cnt <= '0;
            else if (vs_r && hi_cnt != CNT_MAX)
                hi_cnt <= hi_cnt + CNT_ONE;
            if (fall)
                lo_cnt <= '0;
            else if (!vs_r && lo_cnt != CNT_MAX)
                lo_cnt <= lo_cnt + CNT_ONE;
            if (rise) begin
                lo_len <= lo_cnt;
                lo_v   <= 1'b1;
            end
            if (fall) begin
                hi_len <= hi_cnt;
                hi_v   <= 1'b1;
            end
            if (hi_v && lo_v)
                vs_pol <= (hi_len < lo_len);
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        en_nxt     = ypbpr_en;
        blank_nxt  = blank;
        fcnt_nxt   = fcnt;
        case (state)
            IDLE: begin
                if (ypbpr_req != ypbpr_en) begin
                    target_nxt = ypbpr_req;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (ev) begin
                    blank_nxt = 1'b1;
                    state_nxt = PRE;
                end
            end
            PRE: begin
                if (ev) begin
                    en_nxt    = target;
                    fcnt_nxt  = 4'd0;
                    state_nxt = POST;
                end
            end
            POST: begin
                if (ev) begin
                    fcnt_nxt = fcnt + 4'd1;
                    if (fcnt == FCNT_LAST) begin
                        blank_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A timeout only stands in for a frame start that has not arrived yet.
        if (state == IDLE || state_nxt != state || fs || fx)
            timer_nxt = '0;
        else
            timer_nxt = timer + TMR_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            target   <= 1'b0;
            ypbpr_en <= 1'b0;
            blank    <= 1'b0;
            busy     <= 1'b0;
            forced   <= 1'b0;
            fcnt     <= 4'd0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            ypbpr_en <= en_nxt;
            blank    <= blank_nxt;
            busy     <= (state_nxt != IDLE);
            forced   <= fx;
            fcnt     <= fcnt_nxt;
            timer    <= timer_nxt;
        end
    end
endmodule

// File: tb/tb_vga_mode_sched.sv
// Bench for vga_mode_sched: frame-event model checked every cycle on two
// instances (normal timeout and an 8-bit timeout with no vsync).
module tb_vga_mode_sched;
    localparam longint TMAX_A = 64'h3F_FFFF;
    localparam longint TMAX_B = 255;
    localparam longint CMAX   = 64'h3F_FFFF;
    localparam int     BF     = 2;

    typedef struct {
        bit     vr, vd, hv, lv, pol, active, en, target, forced;
        longint hi, lo, hil, lol, tmr;
        int     nev;
    } mdl_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic vsync_a = 1'b0, req_a = 1'b0, vsync_b = 1'b0, req_b = 1'b0;
    logic en_a, blank_a, busy_a, pol_a, forced_a;
    logic en_b, blank_b, busy_b, pol_b, forced_b;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    mdl_t   ma, mb;

    bit     vs_on = 1'b0, vs_inv = 1'b0;
    int     phase = 0;
    longint t_vs_rise = -1, vs_at_blank = -1;
    longint t_req = -1, t_busy_rise = -1, t_busy_fall = -1;
    longint t_blank_rise = -1, t_blank_fall = -1, t_en_rise = -1;
    longint t_b_blank_rise = -1, t_b_en_rise = -1, t_b_blank_fall = -1;
    int     forced_a_cnt = 0;
    longint fb_t[$];
    logic   p_busy = 1'b0, p_blank = 1'b0, p_en = 1'b0, p_blank_b = 1'b0, p_en_b = 1'b0;

    vga_mode_sched dut_a (
        .clk(clk), .reset_n(reset_n), .vsync(vsync_a), .ypbpr_req(req_a),
        .ypbpr_en(en_a), .blank(blank_a), .busy(busy_a), .vs_pol(pol_a), .forced(forced_a)
    );

    vga_mode_sched #(.BLANK_FRAMES(BF), .TO_W(8), .CNT_W(22)) dut_b (
        .clk(clk), .reset_n(reset_n), .vsync(vsync_b), .ypbpr_req(req_b),
        .ypbpr_en(en_b), .blank(blank_b), .busy(busy_b), .vs_pol(pol_b), .forced(forced_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model counts frame events within a switch instead of tracking named states.
    function automatic mdl_t step(input mdl_t m, input bit vs, input bit req, input longint tmax);
        mdl_t n;
        bit   rise, fall, fs, fx;
        n    = m;
        rise = m.vr && !m.vd;
        fall = !m.vr && m.vd;
        fs   = m.pol ? rise : fall;
        fx   = m.active && (m.tmr == tmax);
        n.vd = m.vr;
        n.vr = vs;
        if (rise) n.hi = 0; else if (m.vr && m.hi < CMAX) n.hi = m.hi + 1;
        if (fall) n.lo = 0; else if (!m.vr && m.lo < CMAX) n.lo = m.lo + 1;
        if (rise) begin n.lol = m.lo; n.lv = 1'b1; end
        if (fall) begin n.hil = m.hi; n.hv = 1'b1; end
        if (m.hv && m.lv) n.pol = (m.hil < m.lol);
        n.forced = fx;
        if (!m.active) begin
            n.tmr = 0;
            if (req != m.en) begin
                n.active = 1'b1;
                n.target = req;
                n.nev    = 0;
            end
        end else if (fs || fx) begin
            n.tmr = 0;
            n.nev = m.nev + 1;
            if (n.nev == 2) n.en = m.target;
            if (n.nev == 2 + BF) n.active = 1'b0;
        end else begin
            n.tmr = m.tmr + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = step(ma, vsync_a, req_a, TMAX_A);
            mb = step(mb, vsync_b, req_b, TMAX_B);
        end
    end

    always @(negedge reset_n) begin
        ma = '{default: 0};
        mb = '{default: 0};
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("a_ypbpr_en", en_a, ma.en);
        checkOutput("a_blank", blank_a, ma.active && (ma.nev >= 1));
        checkOutput("a_busy", busy_a, ma.active);
        checkOutput("a_vs_pol", pol_a, ma.pol);
        checkOutput("a_forced", forced_a, ma.forced);
        checkOutput("b_ypbpr_en", en_b, mb.en);
        checkOutput("b_blank", blank_b, mb.active && (mb.nev >= 1));
        checkOutput("b_busy", busy_b, mb.active);
        checkOutput("b_vs_pol", pol_b, mb.pol);
        checkOutput("b_forced", forced_b, mb.forced);
    end

    // Vsync source: 5 clocks high, 995 low (or inverted).
    always @(posedge clk) begin
        #1;
        if (vs_on) begin
            vsync_a = (phase < 5) ^ vs_inv;
            if (phase == 0 && !vs_inv) t_vs_rise = cyc;
            phase = (phase == 999) ? 0 : phase + 1;
        end
    end

    always @(posedge clk) begin
        #3;
        if (busy_a && !p_busy) t_busy_rise = cyc;
        if (!busy_a && p_busy) t_busy_fall = cyc;
        if (blank_a && !p_blank) begin t_blank_rise = cyc; vs_at_blank = t_vs_rise; end
        if (!blank_a && p_blank) t_blank_fall = cyc;
        if (en_a && !p_en) t_en_rise = cyc;
        if (blank_b && !p_blank_b) t_b_blank_rise = cyc;
        if (!blank_b && p_blank_b) t_b_blank_fall = cyc;
        if (en_b && !p_en_b) t_b_en_rise = cyc;
        if (forced_a) forced_a_cnt++;
        if (forced_b) fb_t.push_back(cyc);
        p_busy = busy_a; p_blank = blank_a; p_en = en_a;
        p_blank_b = blank_b; p_en_b = en_b;
    end

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic rb);
        @(posedge clk);
        #2;
        req_a = ra;
        req_b = rb;
        t_req = cyc;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 1100; i++) begin
            if (phase == p) break;
            step_cycles(1);
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint t_tog, t_req_b;
        bit     seen;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            vsync_a = 1'($urandom_range(0, 1));
            req_a   = 1'($urandom_range(0, 1));
            vsync_b = 1'($urandom_range(0, 1));
            req_b   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checkOutput("reset_en", en_a, 1'b0);
        checkOutput("reset_blank", blank_a, 1'b0);
        checkOutput("reset_busy", busy_a, 1'b0);
        checkOutput("reset_pol", pol_a, 1'b0);
        checkOutput("reset_forced", forced_b, 1'b0);
        step_cycles(1);
        vsync_a = 1'b0; req_a = 1'b0; vsync_b = 1'b0; req_b = 1'b0;
        step_cycles(2);
        reset_n = 1'b1;
        step_cycles(20);
        checkOutput("idle_en", en_a, 1'b0);
        checkOutput("idle_busy", busy_a, 1'b0);
        checkOutput("idle_busy_b", busy_b, 1'b0);

        phase = 0;
        vs_on = 1'b1;
        step_cycles(3000);
        checkOutput("pol_active_high", pol_a, 1'b1);
        vs_inv = 1'b1;
        step_cycles(1100);
        checkOutput("pol_inverted", pol_a, 1'b0);
        vs_inv = 1'b0;
        step_cycles(3000);
        checkOutput("pol_restored", pol_a, 1'b1);

        wait_phase(500);
        applyStimulus(1'b1, 1'b0);
        step_cycles(4500);
        checkValue("sw_busy_latency", t_busy_rise - t_req, 1);
        checkValue("sw_blank_after_vs", t_blank_rise - vs_at_blank, 2);
        checkValue("sw_en_after_blank", t_en_rise - t_blank_rise, 1000);
        checkValue("sw_blank_fall", t_blank_fall - t_en_rise, 2000);
        checkValue("sw_busy_with_blank", t_busy_fall, t_blank_fall);
        checkValue("sw_no_forced", forced_a_cnt, 0);
        checkOutput("sw_en_final", en_a, 1'b1);

        applyStimulus(1'b0, 1'b0);
        step_cycles(4500);
        checkOutput("back_en_final", en_a, 1'b0);

        wait_phase(500);
        applyStimulus(1'b1, 1'b0);
        t_tog = cyc;
        step_cycles(10);
        applyStimulus(1'b0, 1'b0);
        step_cycles(4000);
        checkOutput("tog_en_mid", en_a, 1'b1);
        checkOutput("tog_busy_mid", busy_a, 1'b1);
        checkValue("tog_en_rose", longint'(t_en_rise > t_tog), 1);
        checkValue("tog_busy_gap", t_busy_rise - t_busy_fall, 1);
        step_cycles(4000);
        checkOutput("tog_en_final", en_a, 1'b0);
        checkOutput("tog_busy_final", busy_a, 1'b0);

        wait_phase(500);
        applyStimulus(1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (en_a) begin seen = 1'b1; break; end
            step_cycles(1);
        end
        checkValue("rst_reached_post", longint'(seen), 1);
        step_cycles(300);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_en", en_a, 1'b0);
        checkOutput("rst_async_blank", blank_a, 1'b0);
        checkOutput("rst_async_busy", busy_a, 1'b0);
        checkOutput("rst_async_pol", pol_a, 1'b0);
        step_cycles(3);
        reset_n = 1'b1;
        step_cycles(1);
        checkOutput("rst_restart_busy", busy_a, 1'b1);
        step_cycles(6000);
        checkOutput("rst_en_final", en_a, 1'b1);
        checkOutput("rst_busy_final", busy_a, 1'b0);

        applyStimulus(1'b1, 1'b1);
        t_req_b = t_req;
        step_cycles(1200);
        checkValue("to_forced_count", fb_t.size(), 4);
        if (fb_t.size() >= 4) begin
            checkValue("to_first_expiry", fb_t[0] - t_req_b, 257);
            checkValue("to_period", fb_t[1] - fb_t[0], 256);
            checkValue("to_blank_at_1", t_b_blank_rise, fb_t[0]);
            checkValue("to_en_at_2", t_b_en_rise, fb_t[1]);
            checkValue("to_unblank_at_4", t_b_blank_fall, fb_t[3]);
        end
        checkOutput("to_en_final", en_b, 1'b1);
        checkOutput("to_blank_final", blank_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
